// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle multiply/divide unit that owns the HI/LO registers.
// MULT/MULTU/DIV/DIVU compute their result at the Start edge, park it in a
// pending register and commit it to HI/LO after MULT_CYCLES / DIV_CYCLES.
// Optional feature macro: MDU_MADD_EN enables MADD/MADDU (Op 6/7); when it is
// undefined, Op 6/7 are no-ops.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Start,
    input  logic [2:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic        Stall,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_pend_hi;
    logic [31:0] r_pend_lo;
    logic        r_pend_wr;

    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic [31:0] w_div_a;
    logic [31:0] w_div_b;
    logic [31:0] w_q;
    logic [31:0] w_r;
    logic [63:0] w_result;
    logic        w_result_wr;
    logic        w_is_long;
    logic [3:0]  w_cnt_init;

    // Low 64 bits of a product of sign-extended operands are the signed product.
    assign w_prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign w_prod_u = {32'd0, A} * {32'd0, B};

    // Divider works on magnitudes; signs are reapplied afterwards. A zero
    // divisor is replaced by 1 only to keep the datapath defined, the result
    // is never committed in that case.
    always_comb begin
        w_div_a = A;
        w_div_b = B;
        if (Op == 3'd2) begin
            w_div_a = A[31] ? -A : A;
            w_div_b = B[31] ? -B : B;
        end
        if (B == 32'd0) begin
            w_div_b = 32'd1;
        end
        w_q = w_div_a / w_div_b;
        w_r = w_div_a % w_div_b;
    end

    // Decode the op: which result it produces, whether it is multi-cycle and how long.
    always_comb begin
        w_result    = {r_hi, r_lo};
        w_result_wr = 1'b0;
        w_is_long   = 1'b0;
        w_cnt_init  = 4'(MULT_CYCLES - 1);
        case (Op)
            3'd0: begin
                w_is_long   = 1'b1;
                w_result_wr = 1'b1;
                w_result    = w_prod_s;
            end
            3'd1: begin
                w_is_long   = 1'b1;
                w_result_wr = 1'b1;
                w_result    = w_prod_u;
            end
            3'd2: begin
                w_is_long   = 1'b1;
                w_cnt_init  = 4'(DIV_CYCLES - 1);
                w_result_wr = (B != 32'd0);
                w_result    = {(A[31] ? -w_r : w_r), ((A[31] ^ B[31]) ? -w_q : w_q)};
            end
            3'd3: begin
                w_is_long   = 1'b1;
                w_cnt_init  = 4'(DIV_CYCLES - 1);
                w_result_wr = (B != 32'd0);
                w_result    = {w_r, w_q};
            end
`ifdef MDU_MADD_EN
            3'd6: begin
                w_is_long   = 1'b1;
                w_result_wr = 1'b1;
                w_result    = {r_hi, r_lo} + w_prod_s;
            end
            3'd7: begin
                w_is_long   = 1'b1;
                w_result_wr = 1'b1;
                w_result    = {r_hi, r_lo} + w_prod_u;
            end
`endif
            default: ;
        endcase
    end

    // Control FSM: IDLE accepts ops, RUN counts down and commits the pending result.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
            r_pend_wr <= 1'b0;
        end else if (r_state == S_IDLE) begin
            if (Start) begin
                if (w_is_long) begin
                    r_pend_hi <= w_result[63:32];
                    r_pend_lo <= w_result[31:0];
                    r_pend_wr <= w_result_wr;
                    r_cnt     <= w_cnt_init;
                    r_state   <= S_RUN;
                end else if (Op == 3'd4) begin
                    r_hi <= A;
                end else if (Op == 3'd5) begin
                    r_lo <= A;
                end
            end
        end else begin
            // Start is ignored while running.
            if (r_cnt == 4'd0) begin
                if (r_pend_wr) begin
                    r_hi <= r_pend_hi;
                    r_lo <= r_pend_lo;
                end
                r_state <= S_IDLE;
            end else begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    assign Busy  = (r_state == S_RUN);
    assign Stall = Busy | (Start & w_is_long);
    assign HI    = r_hi;
    assign LO    = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed cases plus randomized ops checked against
// a 64-bit arithmetic reference model of HI/LO and the expected busy length.
module tb_mult_div_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        Clk;
    logic        Rst;
    logic        Start;
    logic [2:0]  Op;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic        Stall;
    logic [31:0] HI;
    logic [31:0] LO;

    int          n_vec;
    int          n_err;
    logic [63:0] m_hl;

    mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .A(A), .B(B),
        .Busy(Busy), .Stall(Stall), .HI(HI), .LO(LO)
    );

    // Clock / reset
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_long(input logic [2:0] op);
`ifdef MDU_MADD_EN
        return (op < 3'd4) || (op >= 3'd6);
`else
        return (op < 3'd4);
`endif
    endfunction

    function automatic int exp_cycles(input logic [2:0] op);
        if (!exp_long(op)) return 0;
        return (op == 3'd2 || op == 3'd3) ? DC : MC;
    endfunction

    // Reference model: new {HI,LO} from plain 64-bit arithmetic.
    function automatic logic [63:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [63:0] hl);
        longint sa;
        longint sb;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = hl;
        case (op)
            3'd0: r = 64'(sa * sb);
            3'd1: r = {32'd0, a} * {32'd0, b};
            3'd2: if (b != 0) r = {32'(sa % sb), 32'(sa / sb)};
            3'd3: if (b != 0) r = {a % b, a / b};
            3'd4: r = {a, hl[31:0]};
            3'd5: r = {hl[63:32], a};
`ifdef MDU_MADD_EN
            3'd6: r = hl + 64'(sa * sb);
            3'd7: r = hl + {32'd0, a} * {32'd0, b};
`endif
            default: ;
        endcase
        return r;
    endfunction

    // Driver: issue one op, follow it to completion, check busy length and HI/LO.
    task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit inject);
        logic [63:0] exp_hl;
        int cycles;
        exp_hl = ref_model(op, a, b, m_hl);
        @(negedge Clk);
        Start = 1'b1; Op = op; A = a; B = b;
        #1 check({tag, "_stall"}, 64'(Stall), 64'(exp_long(op)));
        @(negedge Clk);
        Start = 1'b0;
        cycles = 0;
        while (Busy && cycles < 40) begin
            check({tag, "_run_hilo"}, {HI, LO}, m_hl);
            Start = inject && (cycles == 2);
            if (Start) begin
                Op = 3'(($urandom_range(0, 3)));
                A = $urandom;
                B = $urandom;
            end
            #1 check({tag, "_run_stall"}, 64'(Stall), 64'd1);
            @(negedge Clk);
            cycles++;
        end
        Start = 1'b0;
        check({tag, "_busy_cycles"}, 64'(cycles), 64'(exp_cycles(op)));
        check({tag, "_hilo"}, {HI, LO}, exp_hl);
        m_hl = exp_hl;
    endtask

    initial begin
        n_vec = 0; n_err = 0; m_hl = 64'd0;
        Rst = 1'b1; Start = 1'b0; Op = 3'd0; A = 32'd0; B = 32'd0;
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
        check("reset_hilo", {HI, LO}, 64'd0);
        check("reset_busy", 64'(Busy), 64'd0);

        // Reset after arbitrary HI/LO
        do_op("mthi_a", 3'd4, 32'hA5A5_1234, 32'd0, 1'b0);
        do_op("mtlo_a", 3'd5, 32'h5A5A_4321, 32'd0, 1'b0);
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        m_hl = 64'd0;
        check("rst1_hilo", {HI, LO}, 64'd0);
        check("rst1_busy", 64'(Busy), 64'd0);

        // Directed arithmetic
        do_op("mult", 3'd0, 32'd3, 32'hFFFF_FFFE, 1'b0);
        check("mult_lit", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFA);
        do_op("multu", 3'd1, 32'd3, 32'hFFFF_FFFE, 1'b0);
        check("multu_lit", {HI, LO}, 64'h0000_0002_FFFF_FFFA);
        do_op("div", 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check("div_lit", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);
        do_op("divu", 3'd3, 32'd7, 32'd2, 1'b0);
        check("divu_lit", {HI, LO}, 64'h0000_0001_0000_0003);
        do_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check("div_ovf_lit", {HI, LO}, 64'h0000_0000_8000_0000);
        do_op("mthi11", 3'd4, 32'h11, 32'd0, 1'b0);
        do_op("mtlo22", 3'd5, 32'h22, 32'd0, 1'b0);
        do_op("divu_z", 3'd3, 32'd99, 32'd0, 1'b0);
        check("divu_z_lit", {HI, LO}, 64'h0000_0011_0000_0022);
        do_op("div_z", 3'd2, 32'hFFFF_0000, 32'd0, 1'b0);
        do_op("mthi_de", 3'd4, 32'hDEAD_BEEF, 32'd0, 1'b0);
        check("mthi_de_lit", {HI, LO}, 64'hDEAD_BEEF_0000_0022);

        // Start while busy is ignored
        do_op("div_inj", 3'd2, 32'd1000, 32'hFFFF_FFF9, 1'b1);

        // MADDU after HI=0, LO=0xFFFFFFFF
        do_op("mthi0", 3'd4, 32'd0, 32'd0, 1'b0);
        do_op("mtlo_f", 3'd5, 32'hFFFF_FFFF, 32'd0, 1'b0);
        do_op("maddu", 3'd7, 32'd1, 32'd1, 1'b0);
        do_op("madd", 3'd6, 32'hFFFF_FFFF, 32'd3, 1'b0);

        // Reset two cycles into a DIV
        do_op("mthi5", 3'd4, 32'd5, 32'd0, 1'b0);
        @(negedge Clk);
        Start = 1'b1; Op = 3'd2; A = 32'd100; B = 32'd7;
        @(negedge Clk);
        Start = 1'b0;
        @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        m_hl = 64'd0;
        check("rst_mid_busy", 64'(Busy), 64'd0);
        check("rst_mid_hilo", {HI, LO}, 64'd0);
        repeat (DC + 5) @(negedge Clk);
        check("rst_mid_late_busy", 64'(Busy), 64'd0);
        check("rst_mid_late_hilo", {HI, LO}, 64'd0);

        // Randomized ops
        for (int i = 0; i < 60; i++) begin
            logic [2:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 9) == 0) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end
            do_op("rand", op, a, b, ($urandom_range(0, 3) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multiply/divide unit in the EX stage, directly downstream of the register file.
- Consumes the two register read operands (RD1/RD2 after forwarding) and performs multi-cycle MULT/MULTU/DIV/DIVU into the architectural HI/LO registers.
- Supports MTHI/MTLO writes.
- Exposes HI/LO for MFHI/MFLO writeback, and a busy/stall indication for the hazard unit.

Parameters:
- MULT_CYCLES, 5, cycles Busy stays high for MULT/MULTU (and MADD/MADDU when enabled); legal range 1..15.
- DIV_CYCLES, 10, cycles Busy stays high for DIV/DIVU; legal range 1..15.

Ports:
- Clk  input  1  clock; all state updates on posedge.
- Rst  input  1  reset, synchronous, active-high.
- Start  input  1  operation request, qualified by Op.
- Op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MADDU.
- A  input  32  operand rs (dividend / multiplicand / MTHI-MTLO data).
- B  input  32  operand rt (divisor / multiplier).
- Busy  output  1  registered; high while a multi-cycle op is in flight.
- Stall  output  1  combinational: Busy OR (Start AND Op in {0,1,2,3,6,7}); hazard unit stalls MFHI/MFLO/MDU ops on it.
- HI  output  32  architectural HI register.
- LO  output  32  architectural LO register.

Behaviour:
- Reset: at posedge with Rst=1: HI=0, LO=0, Busy=0, counter=0, pending result discarded. Rst has priority over Start, including mid-operation.
- Two states, IDLE (Busy=0) and RUN (Busy=1). Counter is 4-bit.
- IDLE with Start=1 and Op in {0,1,2,3}:
  - At edge k, latch the result into pending_hi/pending_lo (computed from A/B at that edge).
  - Load counter with N−1, where N = MULT_CYCLES or DIV_CYCLES; Busy=1.
- RUN:
  - Each edge decrements the counter.
  - At the edge where counter==0: HI=pending_hi, LO=pending_lo, Busy=0.
  - Net effect: Busy is high for exactly N cycles and HI/LO change at edge k+N.
- Start while Busy=1 (any Op): ignored. The hazard unit guarantees this never occurs; the bench checks it is harmless.
- MTHI/MTLO (Op 4/5) in IDLE:
  - Single cycle; HI or LO = A at edge k.
  - Busy stays 0; the other register is untouched.
- Arithmetic:
  - MULT: signed 32x32 → 64; HI=[63:32], LO=[31:0].
  - MULTU: same, unsigned.
  - DIV: signed; LO=quotient truncated toward zero; HI=remainder with sign of dividend.
  - DIVU: unsigned quotient/remainder.
- Divide by zero (B==0, Op 2/3):
  - Operation still runs the full DIV_CYCLES with Busy high.
  - At completion HI/LO retain their previous values.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- HI/LO are readable every cycle; during RUN they show the old values (MFHI is stalled via Stall).
- Op 6/7: see Optional Feature.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined:
  - Op 6 (MADD) computes {HI,LO} + signed(A)*signed(B); Op 7 (MADDU) computes {HI,LO} + unsigned(A)*unsigned(B).
  - Both use MULT_CYCLES, with 64-bit wrap-around on the sum.
  - The accumulate base is the {HI,LO} value at the Start edge.
- Not defined:
  - Op 6/7 are no-ops: Busy stays 0 and HI/LO are unchanged.
  - Stall excludes Op 6/7.

Test Plan:
- Rst=1 for one edge after arbitrary HI/LO → HI=0, LO=0, Busy=0. Then Rst=1 asserted 2 cycles into a DIV → Busy=0, HI=LO=0, and no later update.
- MULT A=3, B=0xFFFFFFFE (−2) at edge k → Busy high for 5 cycles; at edge k+5 HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU with the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- DIV A=0xFFFFFFF9 (−7), B=2 → after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=7, B=2 → LO=3, HI=1.
- Edge cases:
  - DIV A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0.
  - DIVU with B=0 after HI=0x11, LO=0x22 → Busy high 10 cycles, then HI=0x11, LO=0x22.
- MTHI A=0xDEADBEEF → HI updated next edge, Busy never high, LO unchanged.
- Start with a MULT while Busy (mid-DIV) → ignored; DIV result lands unchanged at its scheduled edge.
- With MDU_MADD_EN, after HI=0, LO=0xFFFFFFFF: MADDU A=1, B=1 → after 5 cycles HI=1, LO=0.
- Without MDU_MADD_EN: the same MADDU stimulus → Busy=0, Stall=0, HI/LO unchanged.
